// File: rtl/ssd1306_spi_receiver_if.sv
// ssd1306_spi_receiver_if
//   4-wire SPI link between the OLED controller (master) and the display-side
//   receiver (slave).
//   sclk  : serial clock, idles high, data sampled on rising edge
//   sdin  : serial data, MSB first
//   cs    : chip select, active low
//   dc    : 0 = command byte, 1 = data byte
//   reset : display reset, active low, synchronous to the system clock
`timescale 1ns/1ps
interface ssd1306_spi_receiver_if;
  logic sclk;
  logic sdin;
  logic cs;
  logic dc;
  logic reset;

  modport master (output sclk, output sdin, output cs, output dc, output reset);
  modport slave  (input  sclk, input  sdin, input  cs, input  dc, input  reset);
endinterface

// File: rtl/ssd1306_spi_receiver.sv
// ssd1306_spi_receiver
//   Display-side end of the SSD1306 4-wire SPI link. Deserialises bytes,
//   executes the command subset emitted by our OLED controller and turns data
//   bytes into framebuffer write strobes with addressing-mode pointer advance.
// Ports:
//   clk, reset    : system clock, asynchronous active-high block reset
//   io (slave)    : sclk/sdin/cs/dc/reset link, synchronous to clk
//   byte_*        : completed-byte pulse, value and dc flag
//   wr_*          : framebuffer write strobe, {page,col} address and data
//   cmd_*         : command-complete pulse, opcode, unknown flag, count
//   display_on, inverted, contrast, addr_mode, charge_pump : decoded state
`timescale 1ns/1ps
module ssd1306_spi_receiver #(
  parameter int COLUMNS = 128,
  parameter int PAGES   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  ssd1306_spi_receiver_if.slave  io,
  output logic                   byte_valid,
  output logic [7:0]             byte_data,
  output logic                   byte_is_data,
  output logic                   wr_en,
  output logic [9:0]             wr_addr,
  output logic [7:0]             wr_data,
  output logic                   cmd_done,
  output logic [7:0]             cmd_opcode,
  output logic                   cmd_unknown,
  output logic [7:0]             cmd_count,
  output logic                   display_on,
  output logic                   inverted,
  output logic [7:0]             contrast,
  output logic [1:0]             addr_mode,
  output logic                   charge_pump
);

  localparam logic [6:0] COL_MAX  = 7'(COLUMNS - 1);
  localparam logic [2:0] PAGE_MAX = 3'(PAGES - 1);

  // Number of argument bytes that follow an opcode.
  function automatic logic [1:0] op_nargs(input logic [7:0] op);
    case (op)
      8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D: op_nargs = 2'd1;
      8'h21, 8'h22:                                           op_nargs = 2'd2;
      default:                                                op_nargs = 2'd0;
    endcase
  endfunction

  // True for every opcode in the decoded set (with or without arguments).
  function automatic logic op_known(input logic [7:0] op);
    if (op[7:6] == 2'b01) begin
      op_known = 1'b1;  // 0x40-0x7F display start line
    end else begin
      case (op)
        8'hAE, 8'hAF, 8'hA6, 8'hA7, 8'hA4, 8'hA5,
        8'hC0, 8'hC8, 8'hA0, 8'hA1,
        8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D,
        8'h21, 8'h22: op_known = 1'b1;
        default:      op_known = 1'b0;
      endcase
    end
  endfunction

  logic       sclk_q;
  logic [7:0] shift_q,        shift_d;
  logic [2:0] bit_cnt_q,      bit_cnt_d;
  logic       byte_valid_q,   byte_valid_d;
  logic [7:0] byte_data_q,    byte_data_d;
  logic       byte_is_data_q, byte_is_data_d;
  logic       wr_en_q,        wr_en_d;
  logic [9:0] wr_addr_q,      wr_addr_d;
  logic [7:0] wr_data_q,      wr_data_d;
  logic       cmd_done_q,     cmd_done_d;
  logic [7:0] cmd_opcode_q,   cmd_opcode_d;
  logic       cmd_unknown_q,  cmd_unknown_d;
  logic [7:0] cmd_count_q,    cmd_count_d;
  logic       display_on_q,   display_on_d;
  logic       inverted_q,     inverted_d;
  logic [7:0] contrast_q,     contrast_d;
  logic [1:0] addr_mode_q,    addr_mode_d;
  logic       charge_pump_q,  charge_pump_d;
  logic [6:0] col_q,          col_d;
  logic [2:0] page_q,         page_d;
  logic [6:0] col_start_q,    col_start_d;
  logic [6:0] col_end_q,      col_end_d;
  logic [2:0] page_start_q,   page_start_d;
  logic [2:0] page_end_q,     page_end_d;
  logic [1:0] arg_cnt_q,      arg_cnt_d;   // arguments still expected
  logic [7:0] cur_op_q,       cur_op_d;    // opcode awaiting arguments
  logic [7:0] arg0_q,         arg0_d;      // first argument of 0x21/0x22

  logic       sclk_rise_s;
  logic       byte_done_s;
  logic [7:0] byte_s;
  logic       fin_s;       // a command completes on this byte
  logic [7:0] fin_op_s;    // opcode of the completing command

  // Only rising edges seen while selected advance the shifter.
  assign sclk_rise_s = ~sclk_q & io.sclk & ~io.cs;
  assign byte_s      = {shift_q[6:0], io.sdin};
  assign byte_done_s = sclk_rise_s & (bit_cnt_q == 3'd7);

  // Serial clock history for edge detection; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= 1'b1;
    end else begin
      sclk_q <= io.sclk;
    end
  end

  // Next-state logic: bit capture, command decode, data writes, pointer advance.
  always_comb begin
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    byte_valid_d   = 1'b0;
    byte_data_d    = byte_data_q;
    byte_is_data_d = byte_is_data_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    cmd_done_d     = 1'b0;
    cmd_opcode_d   = cmd_opcode_q;
    cmd_unknown_d  = 1'b0;
    cmd_count_d    = cmd_count_q;
    display_on_d   = display_on_q;
    inverted_d     = inverted_q;
    contrast_d     = contrast_q;
    addr_mode_d    = addr_mode_q;
    charge_pump_d  = charge_pump_q;
    col_d          = col_q;
    page_d         = page_q;
    col_start_d    = col_start_q;
    col_end_d      = col_end_q;
    page_start_d   = page_start_q;
    page_end_d     = page_end_q;
    arg_cnt_d      = arg_cnt_q;
    cur_op_d       = cur_op_q;
    arg0_d         = arg0_q;
    fin_s          = 1'b0;
    fin_op_s       = 8'h00;

    if (!io.reset) begin
      // Display reset wins over any byte completing in the same cycle.
      shift_d        = 8'h00;
      bit_cnt_d      = 3'd0;
      byte_data_d    = 8'h00;
      byte_is_data_d = 1'b0;
      wr_addr_d      = 10'h000;
      wr_data_d      = 8'h00;
      cmd_opcode_d   = 8'h00;
      cmd_count_d    = 8'h00;
      display_on_d   = 1'b0;
      inverted_d     = 1'b0;
      contrast_d     = 8'h7F;
      addr_mode_d    = 2'b10;
      charge_pump_d  = 1'b0;
      col_d          = 7'd0;
      page_d         = 3'd0;
      col_start_d    = 7'd0;
      col_end_d      = COL_MAX;
      page_start_d   = 3'd0;
      page_end_d     = PAGE_MAX;
      arg_cnt_d      = 2'd0;
      cur_op_d       = 8'h00;
      arg0_d         = 8'h00;
    end else begin
      // Deselect discards a partial byte; arg_cnt survives so commands can
      // straddle the cs toggling the controller does between bytes.
      if (io.cs) begin
        shift_d   = 8'h00;
        bit_cnt_d = 3'd0;
      end else if (sclk_rise_s) begin
        shift_d   = byte_s;
        bit_cnt_d = bit_cnt_q + 3'd1;  // wraps to 0 after the 8th bit
      end else begin
        shift_d   = shift_q;
      end

      if (byte_done_s) begin
        byte_valid_d   = 1'b1;
        byte_data_d    = byte_s;
        byte_is_data_d = io.dc;
        if (io.dc) begin
          // A data byte abandons any command still waiting for arguments.
          arg_cnt_d = 2'd0;
          wr_en_d   = 1'b1;
          wr_addr_d = {page_q, col_q};
          wr_data_d = byte_s;
          case (addr_mode_q)
            2'b00: begin
              if (col_q == col_end_q) begin
                col_d  = col_start_q;
                page_d = (page_q == page_end_q) ? page_start_q : page_q + 3'd1;
              end else begin
                col_d  = col_q + 7'd1;
              end
            end
            2'b01: begin
              if (page_q == page_end_q) begin
                page_d = page_start_q;
                col_d  = (col_q == col_end_q) ? col_start_q : col_q + 7'd1;
              end else begin
                page_d = page_q + 3'd1;
              end
            end
            default: begin
              // Page mode (and the reserved 11 encoding): column wraps only.
              col_d = (col_q == col_end_q) ? col_start_q : col_q + 7'd1;
            end
          endcase
        end else if (arg_cnt_q == 2'd0) begin
          if (op_nargs(byte_s) == 2'd0) begin
            fin_s    = 1'b1;
            fin_op_s = byte_s;
          end else begin
            cur_op_d  = byte_s;
            arg_cnt_d = op_nargs(byte_s);
          end
        end else begin
          arg_cnt_d = arg_cnt_q - 2'd1;
          if (arg_cnt_q == 2'd1) begin
            fin_s    = 1'b1;
            fin_op_s = cur_op_q;
          end else begin
            arg0_d   = byte_s;
          end
        end
      end else begin
        byte_valid_d = 1'b0;
      end

      // Effects are applied only once the whole command has arrived, so an
      // abandoned command leaves the decoded state untouched.
      if (fin_s) begin
        cmd_done_d    = 1'b1;
        cmd_opcode_d  = fin_op_s;
        cmd_unknown_d = ~op_known(fin_op_s);
        cmd_count_d   = (cmd_count_q == 8'hFF) ? 8'hFF : cmd_count_q + 8'd1;
        case (fin_op_s)
          8'hAE: display_on_d  = 1'b0;
          8'hAF: display_on_d  = 1'b1;
          8'hA6: inverted_d    = 1'b0;
          8'hA7: inverted_d    = 1'b1;
          8'h81: contrast_d    = byte_s;
          8'h20: addr_mode_d   = byte_s[1:0];
          8'h8D: charge_pump_d = byte_s[2];
          8'h21: begin
            col_start_d = arg0_q[6:0];
            col_end_d   = byte_s[6:0];
            col_d       = arg0_q[6:0];
          end
          8'h22: begin
            page_start_d = arg0_q[2:0];
            page_end_d   = byte_s[2:0];
            page_d       = arg0_q[2:0];
          end
          default: cmd_unknown_d = ~op_known(fin_op_s);
        endcase
      end else begin
        cmd_done_d = 1'b0;
      end
    end
  end

  // State register with asynchronous block reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q        <= 8'h00;
      bit_cnt_q      <= 3'd0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'h00;
      byte_is_data_q <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= 10'h000;
      wr_data_q      <= 8'h00;
      cmd_done_q     <= 1'b0;
      cmd_opcode_q   <= 8'h00;
      cmd_unknown_q  <= 1'b0;
      cmd_count_q    <= 8'h00;
      display_on_q   <= 1'b0;
      inverted_q     <= 1'b0;
      contrast_q     <= 8'h7F;
      addr_mode_q    <= 2'b10;
      charge_pump_q  <= 1'b0;
      col_q          <= 7'd0;
      page_q         <= 3'd0;
      col_start_q    <= 7'd0;
      col_end_q      <= COL_MAX;
      page_start_q   <= 3'd0;
      page_end_q     <= PAGE_MAX;
      arg_cnt_q      <= 2'd0;
      cur_op_q       <= 8'h00;
      arg0_q         <= 8'h00;
    end else begin
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      cmd_done_q     <= cmd_done_d;
      cmd_opcode_q   <= cmd_opcode_d;
      cmd_unknown_q  <= cmd_unknown_d;
      cmd_count_q    <= cmd_count_d;
      display_on_q   <= display_on_d;
      inverted_q     <= inverted_d;
      contrast_q     <= contrast_d;
      addr_mode_q    <= addr_mode_d;
      charge_pump_q  <= charge_pump_d;
      col_q          <= col_d;
      page_q         <= page_d;
      col_start_q    <= col_start_d;
      col_end_q      <= col_end_d;
      page_start_q   <= page_start_d;
      page_end_q     <= page_end_d;
      arg_cnt_q      <= arg_cnt_d;
      cur_op_q       <= cur_op_d;
      arg0_q         <= arg0_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign byte_is_data = byte_is_data_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cmd_done     = cmd_done_q;
  assign cmd_opcode   = cmd_opcode_q;
  assign cmd_unknown  = cmd_unknown_q;
  assign cmd_count    = cmd_count_q;
  assign display_on   = display_on_q;
  assign inverted     = inverted_q;
  assign contrast     = contrast_q;
  assign addr_mode    = addr_mode_q;
  assign charge_pump  = charge_pump_q;

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// tb_ssd1306_spi_receiver
//   Drives the SPI link at the fastest controller rate and compares every
//   completed byte against a byte-level reference model of the display.
`timescale 1ns/1ps
module tb_ssd1306_spi_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       byte_valid, byte_is_data, wr_en, cmd_done, cmd_unknown;
  logic       display_on, inverted, charge_pump;
  logic [7:0] byte_data, wr_data, cmd_opcode, cmd_count, contrast;
  logic [9:0] wr_addr;
  logic [1:0] addr_mode;

  ssd1306_spi_receiver_if io_if ();

  ssd1306_spi_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .io           (io_if),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cmd_done     (cmd_done),
    .cmd_opcode   (cmd_opcode),
    .cmd_unknown  (cmd_unknown),
    .cmd_count    (cmd_count),
    .display_on   (display_on),
    .inverted     (inverted),
    .contrast     (contrast),
    .addr_mode    (addr_mode),
    .charge_pump  (charge_pump)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  int bv_count  = 0;
  int unk_count = 0;

  // Event counters observed away from the active edge.
  always @(negedge clk) begin
    if (byte_valid)  bv_count++;
    if (cmd_unknown) unk_count++;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  // ---------------- reference model (byte level) ----------------
  int         m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode;
  int         m_contrast, m_disp, m_inv, m_cp, m_count;
  logic [7:0] m_cmdq[$];
  bit         e_wr, e_done, e_unk;
  int         e_addr;
  logic [7:0] e_op;

  function automatic int nargs(input logic [7:0] op);
    case (op)
      8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D: return 1;
      8'h21, 8'h22: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_unknown(input logic [7:0] op);
    if (op >= 8'h40 && op <= 8'h7F) return 1'b0;
    if (nargs(op) != 0) return 1'b0;
    case (op)
      8'hAE, 8'hAF, 8'hA6, 8'hA7, 8'hA4, 8'hA5, 8'hC0, 8'hC8, 8'hA0, 8'hA1: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_mode = 2; m_contrast = 8'h7F; m_disp = 0; m_inv = 0; m_cp = 0; m_count = 0;
    m_cmdq.delete();
    e_op = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic dc);
    logic [7:0] a1;
    e_wr = 1'b0; e_done = 1'b0; e_unk = 1'b0;
    if (dc) begin
      m_cmdq.delete();
      e_wr   = 1'b1;
      e_addr = m_page * 128 + m_col;
      if (m_mode == 0) begin
        if (m_col == m_ce) begin
          m_col  = m_cs;
          m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
        end else m_col = (m_col + 1) % 128;
      end else if (m_mode == 1) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_col  = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
        end else m_page = (m_page + 1) % 8;
      end else begin
        m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
      end
    end else begin
      m_cmdq.push_back(b);
      if (m_cmdq.size() == 1 + nargs(m_cmdq[0])) begin
        e_done  = 1'b1;
        e_op    = m_cmdq[0];
        e_unk   = is_unknown(e_op);
        m_count = (m_count == 255) ? 255 : m_count + 1;
        a1      = (m_cmdq.size() > 1) ? m_cmdq[1] : 8'h00;
        case (e_op)
          8'hAE: m_disp = 0;
          8'hAF: m_disp = 1;
          8'hA6: m_inv = 0;
          8'hA7: m_inv = 1;
          8'h81: m_contrast = a1;
          8'h20: m_mode = a1 % 4;
          8'h8D: m_cp = a1[2];
          8'h21: begin m_cs = a1 % 128; m_ce = m_cmdq[2] % 128; m_col = m_cs; end
          8'h22: begin m_ps = a1 % 8; m_pe = m_cmdq[2] % 8; m_page = m_ps; end
          default: ;
        endcase
        m_cmdq.delete();
      end
    end
  endtask

  // ---------------- checking and driving ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".cmd_count"},   32'(cmd_count),   32'(m_count));
    check({tag, ".contrast"},    32'(contrast),    32'(m_contrast));
    check({tag, ".addr_mode"},   32'(addr_mode),   32'(m_mode));
    check({tag, ".display_on"},  32'(display_on),  32'(m_disp));
    check({tag, ".inverted"},    32'(inverted),    32'(m_inv));
    check({tag, ".charge_pump"}, 32'(charge_pump), 32'(m_cp));
  endtask

  task automatic check_defaults(input string tag);
    check({tag, ".byte_valid"}, 32'(byte_valid),  32'd0);
    check({tag, ".wr_en"},      32'(wr_en),       32'd0);
    check({tag, ".cmd_done"},   32'(cmd_done),    32'd0);
    check({tag, ".byte_data"},  32'(byte_data),   32'd0);
    check({tag, ".count"},      32'(cmd_count),   32'd0);
    check({tag, ".disp"},       32'(display_on),  32'd0);
    check({tag, ".inv"},        32'(inverted),    32'd0);
    check({tag, ".contrast"},   32'(contrast),    32'h7F);
    check({tag, ".mode"},       32'(addr_mode),   32'd2);
    check({tag, ".cp"},         32'(charge_pump), 32'd0);
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    io_if.sclk = 1'b0; io_if.sdin = b;
    @(posedge clk); #1;
    io_if.sclk = 1'b1;
  endtask

  // One byte at full rate, checked in the byte_valid cycle and the cycle after.
  task automatic send_byte(input logic [7:0] b, input logic dc, input bit toggle_cs);
    io_if.cs = 1'b0;
    io_if.dc = dc;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    @(posedge clk); #1;
    model_byte(b, dc);
    check("byte_valid",   32'(byte_valid),   32'd1);
    check("byte_data",    32'(byte_data),    32'(b));
    check("byte_is_data", 32'(byte_is_data), 32'(dc));
    check("wr_en",        32'(wr_en),        32'(e_wr));
    check("cmd_done",     32'(cmd_done),     32'(e_done));
    if (e_wr) begin
      check("wr_addr", 32'(wr_addr), 32'(e_addr));
      check("wr_data", 32'(wr_data), 32'(b));
    end
    if (e_done) begin
      check("cmd_opcode",  32'(cmd_opcode),  32'(e_op));
      check("cmd_unknown", 32'(cmd_unknown), 32'(e_unk));
    end
    check_state("byte");
    if (toggle_cs) io_if.cs = 1'b1;
    @(posedge clk); #1;
    check("pulse_end", 32'({byte_valid, wr_en, cmd_done}), 32'd0);
  endtask

  logic [7:0] init_seq [23] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h01, 8'hC8, 8'h40,
                                8'hA1, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9,
                                8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};
  logic [7:0] ops [24] = '{8'hAE, 8'hAF, 8'hA6, 8'hA7, 8'hA4, 8'hA5, 8'hC0, 8'hC8,
                           8'hA0, 8'hA1, 8'h40, 8'h7F, 8'h81, 8'h20, 8'hA8, 8'hD3,
                           8'hD5, 8'hD9, 8'hDB, 8'h8D, 8'h21, 8'h22, 8'h00, 8'hE3};
  logic [9:0] h_addr [6] = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h090, 10'h091};

  initial begin
    int bv0;
    logic [7:0] b;
    logic dc;

    reset = 1'b1;
    io_if.sclk = 1'b1; io_if.sdin = 1'b0; io_if.cs = 1'b1;
    io_if.dc = 1'b0; io_if.reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_defaults("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Controller init stream, cs toggled between bytes.
    for (int i = 0; i < 23; i++) send_byte(init_seq[i], 1'b0, 1'b1);
    check("init.count",    32'(cmd_count),   32'd15);
    check("init.contrast", 32'(contrast),    32'h7F);
    check("init.mode",     32'(addr_mode),   32'd1);
    check("init.cp",       32'(charge_pump), 32'd1);
    check("init.disp",     32'(display_on),  32'd1);
    check("init.unknown",  32'(unk_count),   32'd0);

    // 1025 data bytes in vertical mode.
    for (int i = 0; i < 1025; i++) begin
      send_byte(8'(i % 256), 1'b1, 1'($urandom_range(0, 1)));
      if (i == 0)    check("vert.b0",    32'(wr_addr), 32'h000);
      if (i == 1)    check("vert.b1",    32'(wr_addr), 32'h080);
      if (i == 8)    check("vert.b8",    32'(wr_addr), 32'h001);
      if (i == 1023) check("vert.b1023", 32'(wr_addr), 32'h3FF);
      if (i == 1024) check("vert.b1024", 32'(wr_addr), 32'h000);
    end

    // Horizontal mode with a 4-column window.
    send_byte(8'h20, 1'b0, 1'b1); send_byte(8'h00, 1'b0, 1'b1);
    send_byte(8'h22, 1'b0, 1'b1); send_byte(8'h00, 1'b0, 1'b1); send_byte(8'h07, 1'b0, 1'b1);
    send_byte(8'h21, 1'b0, 1'b1); send_byte(8'h10, 1'b0, 1'b0); send_byte(8'h13, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      check("horiz.addr", 32'(wr_addr), 32'(h_addr[i]));
    end

    // Partial byte discarded by cs, then a full 0xA7.
    io_if.cs = 1'b0; io_if.dc = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    @(posedge clk); #1; io_if.cs = 1'b1;
    @(posedge clk); #1;
    bv0 = bv_count;
    send_byte(8'hA7, 1'b0, 1'b1);
    check("partial.bv",  32'(bv_count - bv0), 32'd1);
    check("partial.inv", 32'(inverted),       32'd1);

    // Data byte abandons a pending 0x81.
    send_byte(8'h81, 1'b0, 1'b1);
    send_byte(8'h55, 1'b1, 1'b1);
    check("abandon.contrast", 32'(contrast), 32'h7F);

    // Randomised mix of commands, arguments and data.
    for (int i = 0; i < 300; i++) begin
      dc = 1'($urandom_range(0, 1));
      b  = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 23)] : 8'($urandom_range(0, 255));
      send_byte(b, dc, 1'($urandom_range(0, 1)));
    end

    // Display reset in the middle of a byte.
    io_if.cs = 1'b0; io_if.dc = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    @(posedge clk); #1; io_if.reset = 1'b0;
    @(posedge clk); #1; io_if.reset = 1'b1;
    check_defaults("ioreset");
    model_reset();
    send_byte(8'hAF, 1'b0, 1'b0);
    check("ioreset.disp", 32'(display_on), 32'd1);

    // Display reset coinciding with the 8th edge drops the byte.
    b = 8'hA7;
    io_if.cs = 1'b0;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    @(posedge clk); #1; io_if.sclk = 1'b0; io_if.sdin = b[0];
    @(posedge clk); #1; io_if.sclk = 1'b1; io_if.reset = 1'b0;
    bv0 = bv_count;
    @(posedge clk); #1; io_if.reset = 1'b1;
    check("ioreset8.bv_now", 32'(byte_valid), 32'd0);
    @(posedge clk); #1;
    check("ioreset8.bv_cnt", 32'(bv_count - bv0), 32'd0);
    check("ioreset8.inv",    32'(inverted),       32'd0);
    model_reset();
    io_if.cs = 1'b1;
    send_byte(8'hAF, 1'b0, 1'b1);

    // Asynchronous reset between clock edges, mid-byte.
    io_if.cs = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_defaults("async");
    #1;
    reset = 1'b0;
    model_reset();
    send_byte(8'hA7, 1'b0, 1'b1);
    check("async.inv", 32'(inverted), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
